// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM states, oversample
// ratio, majority-vote tick positions and the vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] VOTE_T0    = 4'd7;
    localparam logic [3:0] VOTE_T1    = 4'd8;
    localparam logic [3:0] VOTE_T2    = 4'd9;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO between the UART deframer and the register interface. Push is
// refused when full unless a pop happens in the same cycle; pop is refused when empty.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; emptiness comes from the pointers and head_data is masked.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 UART receiver with majority voting feeding a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a live parity_err flag.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_rx,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int            DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tick_idx_q, tick_idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;

    logic tick, vote, vote_tick, window_end;
    logic push, frame_set, overrun_set;
    logic fifo_full, fifo_empty;

    assign tick       = (div_cnt_q == DIV_LAST);
    assign vote       = majority3(samp_q[0], samp_q[1], sync2_q);
    assign vote_tick  = tick && (tick_idx_q == VOTE_T2);
    assign window_end = tick && (tick_idx_q == LAST_TICK);

    always_comb begin
        sync1_d    = uart_rx;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
        tick_idx_d = tick ? tick_idx_q + 4'd1 : tick_idx_q;
        bit_idx_d  = bit_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;

        if (tick && tick_idx_q == VOTE_T0) samp_d[0] = sync2_q;
        if (tick && tick_idx_q == VOTE_T1) samp_d[1] = sync2_q;

        case (state_q)
            IDLE: begin
                // Falling edge restarts the divider so windows align to the start bit.
                if (prev_q && !sync2_q) begin
                    state_d    = START;
                    div_cnt_d  = '0;
                    tick_idx_d = '0;
                end
            end
            START: begin
                if (vote_tick && vote) begin
                    state_d = IDLE;
                end else if (window_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (vote_tick) shift_d = {vote, shift_q[7:1]};
                if (window_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (window_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at the vote, not the window end, so a short stop bit cannot hide the next start.
                if (vote_tick) begin
                    push      = vote;
                    frame_set = ~vote;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_set = push & fifo_full & ~rd_en;
        frame_err_d = frame_set | (frame_err_q & ~clr_err);
        overrun_d   = overrun_set | (overrun_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            div_cnt_q   <= '0;
            tick_idx_q  <= '0;
            bit_idx_q   <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            div_cnt_q   <= div_cnt_d;
            tick_idx_q  <= tick_idx_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d, parity_set;

    always_comb begin
        parity_set   = (state_q == PARITY) && vote_tick && (vote != ^shift_q);
        parity_err_d = parity_set | (parity_err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q),
        .pop       (rd_en),
        .head_data (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
